// File: rtl/signed_mult_seq.sv
// Sequential signed multiplier: magnitude shift-add, one bit per clock.
// Optional SIGNED_MULT_ZERO_SKIP_EN finishes zero-operand requests in one edge.
module twos_complement #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    assign y_o = ~x_i + W'(1);
endmodule

module signed_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SIGN
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ma_q, ma_d;
    logic [WIDTH-1:0]  mb_q, mb_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  a_neg, b_neg;
    logic [PW-1:0]     acc_neg;
    logic [WIDTH-1:0]  ma_c, mb_c;
    logic [PW-1:0]     addend;
    logic              zero;

    twos_complement #(.W(WIDTH)) u_neg_a (.x_i(a), .y_o(a_neg));
    twos_complement #(.W(WIDTH)) u_neg_b (.x_i(b), .y_o(b_neg));
    twos_complement #(.W(PW))    u_neg_p (.x_i(acc_q), .y_o(acc_neg));

    // 0x80 negates to itself; read as unsigned it is the correct magnitude
    assign ma_c   = a[WIDTH-1] ? a_neg : a;
    assign mb_c   = b[WIDTH-1] ? b_neg : b;
    assign addend = {{WIDTH{1'b0}}, ma_q} << cnt_q;

`ifdef SIGNED_MULT_ZERO_SKIP_EN
    assign zero = (a == '0) || (b == '0);
`else
    assign zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero) begin
                        prod_d = '0;
                        done_d = 1'b1;
                    end else begin
                        ma_d    = ma_c;
                        mb_d    = mb_c;
                        neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (mb_q[0]) acc_d = acc_q + addend;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = SIGN;
            end
            SIGN: begin
                prod_d  = neg_q ? acc_neg : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = prod_q;
endmodule

// File: tb/tb_signed_mult_seq.sv
// Scoreboard bench for signed_mult_seq: expected product and done cycle
// are queued at acceptance and checked when done pulses.
module tb_signed_mult_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    signed_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    localparam int LAT = 9;
`ifdef SIGNED_MULT_ZERO_SKIP_EN
    localparam int ZLAT  = 0;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 9;
    localparam int ZBUSY = 9;
`endif

    typedef struct {
        logic [15:0] p;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_vec = 0;
    int n_err = 0;
    int bc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] xs, ys, p;
        xs = {{8{x[7]}}, x};
        ys = {{8{y[7]}}, y};
        p  = xs * ys;
        return p;
    endfunction

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [15:0] ep, input int lat);
        exp_t n;
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n.p   = ep;
        n.at  = cyc + lat;
        sb.push_back(n);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) cnt++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("product", 32'(product), 32'(e.p));
                chk("latency", cyc, e.at);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_prod", 32'(product), 0);

        issue(8'd3, 8'd5, 16'h000F, LAT);
        wait_done(bc);
        chk("busy_cycles", bc, 9);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);

        issue(8'd2, 8'd3, 16'h0006, LAT);
        repeat (3) @(posedge clk);
        #1;
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(bc);
        issue(8'hFE, 8'd3, 16'hFFFA, LAT);
        wait_done(bc);
        chk("b2b_busy", bc, 9);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);

        issue(8'd7, 8'd7, 16'd49, LAT);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_prod", 32'(product), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end

        issue(8'h00, 8'hF9, 16'h0000, ZLAT);
        wait_done(bc);
        chk("zero_busy", bc, ZBUSY);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (ra == 8'd0 || rb == 8'd0) issue(ra, rb, model(ra, rb), ZLAT);
            else issue(ra, rb, model(ra, rb), LAT);
            wait_done(bc);
        end

        issue(8'h80, 8'h80, 16'h4000, LAT);
        wait_done(bc);
        issue(8'h80, 8'h7F, 16'hC080, LAT);
        wait_done(bc);
        issue(8'hFF, 8'h01, 16'hFFFF, LAT);
        wait_done(bc);
        issue(8'h7F, 8'h7F, 16'h3F01, LAT);
        wait_done(bc);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_prod", 32'(product), 32'h3F01);
            chk("hold_done", 32'(done), 0);
        end
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
